// File: rtl/scan_ctrl.sv
// Emulation scan-chain sequencer: gates the DUT clock enable (run/stop/step)
// and performs a full-length scan swap between the host streams and the chain.
//
// state | meaning
// IDLE  | DUT clock stopped, commands accepted
// RUN   | DUT clock enabled free-running, commands accepted
// STEP  | DUT clock enabled for the remaining step count
// SHIFT | chain swap in progress, one bit per host handshake beat
module scan_ctrl #(
  parameter int CHAIN_LEN = 9,
  parameter int STEP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              si_valid,
  output logic              si_ready,
  input  logic              si_data,
  output logic              so_valid,
  input  logic              so_ready,
  output logic              so_data,
  output logic              dut_clk_en,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycle_count
);

  localparam int BEAT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_SCAN = 2'd3;

  state_t              state;
  logic [STEP_W-1:0]   step_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                accept;
  logic                beat;

  assign cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign busy      = (state == S_STEP) || (state == S_SHIFT);
  assign accept    = cmd_valid && cmd_ready;

  // Beat strobes are combinational so a stalled host costs no extra cycle.
  assign beat      = (state == S_SHIFT) && si_valid && so_ready;
  assign scan_en   = beat;
  assign si_ready  = beat;
  assign so_valid  = beat;
  assign scan_in   = si_data;
  assign so_data   = scan_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      beat_cnt    <= '0;
      dut_clk_en  <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      done <= 1'b0;
      if (dut_clk_en) cycle_count <= cycle_count + 32'd1;

      case (state)
        S_STEP: begin
          if (step_cnt == STEP_W'(1)) begin
            state      <= S_IDLE;
            dut_clk_en <= 1'b0;
            done       <= 1'b1;
            step_cnt   <= '0;
          end else begin
            step_cnt <= step_cnt - STEP_W'(1);
          end
        end
        S_SHIFT: begin
          if (beat) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= S_IDLE;
              done     <= 1'b1;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase

      // Only reachable from IDLE/RUN, so never collides with the branches above.
      if (accept) begin
        case (cmd_op)
          OP_STOP: begin
            state      <= S_IDLE;
            dut_clk_en <= 1'b0;
          end
          OP_RUN: begin
            state      <= S_RUN;
            dut_clk_en <= 1'b1;
          end
          OP_STEP: begin
            if (cmd_arg == '0) begin
              state      <= S_IDLE;
              dut_clk_en <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= S_STEP;
              dut_clk_en <= 1'b1;
              step_cnt   <= cmd_arg;
            end
          end
          default: begin
            state      <= S_SHIFT;
            dut_clk_en <= 1'b0;
            beat_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: directed vector table, scan-swap sequences
// and randomized traffic against a per-cycle behavioural model with a chain model.
module tb_scan_ctrl;

  localparam int LEN = 9;
  localparam int SW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [SW-1:0] cmd_arg = '0;
  logic          si_valid = 1'b0;
  logic          si_ready;
  logic          si_data = 1'b0;
  logic          so_valid;
  logic          so_ready = 1'b0;
  logic          so_data;
  logic          dut_clk_en;
  logic          scan_en;
  logic          scan_in;
  logic          scan_out;
  logic          busy;
  logic          done;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  scan_ctrl #(.CHAIN_LEN(LEN), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data),
    .dut_clk_en(dut_clk_en), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  // Scan chain of the instrumented DUT: bit 0 is the tail, new bits enter at the head.
  logic [LEN-1:0] chain = '0;
  logic           chain_load = 1'b0;
  logic [LEN-1:0] chain_val = '0;
  always @(posedge clk) begin
    if (chain_load) chain <= chain_val;
    else if (scan_en) chain <= {scan_in, chain[LEN-1:1]};
  end
  assign scan_out = chain[0];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 step, 3 shift.
  int          md = 0;
  int          en_left = 0;
  int          beats = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_cc = '0;
  logic        m_beat;
  bit          mon_on = 1'b0;

  assign m_beat = (md == 3) && si_valid && so_ready;

  always @(posedge clk) begin
    if (rst) begin
      md = 0; en_left = 0; beats = 0; m_done = 1'b0; m_cc = '0;
    end else begin
      if (md == 1 || md == 2) m_cc = m_cc + 32'd1;
      m_done = 1'b0;
      if (md == 2) begin
        en_left--;
        if (en_left == 0) begin md = 0; m_done = 1'b1; end
      end else if (md == 3) begin
        if (si_valid && so_ready) begin
          beats++;
          if (beats == LEN) begin md = 0; m_done = 1'b1; end
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: md = 0;
          2'd1: md = 1;
          2'd2: begin
            if (cmd_arg == 0) begin md = 0; m_done = 1'b1; end
            else begin md = 2; en_left = int'(cmd_arg); end
          end
          default: begin md = 3; beats = 0; end
        endcase
      end
    end
  end

  int done_cnt = 0;
  int se_cnt = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (scan_en === 1'b1) se_cnt++;
    if (scan_en === 1'b1 && dut_clk_en === 1'b1) overlap_cnt++;
    if (mon_on) begin
      check("model_outputs", {25'd0, cmd_ready, busy, done, dut_clk_en, scan_en, si_ready, so_valid},
            {25'd0, md < 2, md >= 2, m_done, (md == 1 || md == 2), m_beat, m_beat, m_beat});
      check("model_cycle_count", cycle_count, m_cc);
      if (m_beat) begin
        check("model_scan_in", {31'd0, scan_in}, {31'd0, si_data});
        check("model_so_data", {31'd0, so_data}, {31'd0, chain[0]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [SW-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Issue SCAN and feed beats with so_ready toggling; stops after kill_after beats.
  task automatic do_scan(input logic [LEN-1:0] si_bits, input int kill_after,
                         output logic [LEN-1:0] so_bits, output int nb);
    logic ph;
    ph = 1'b0;
    nb = 0;
    so_bits = '0;
    issue(2'd3, '0);
    for (int c = 0; c < 80 && nb < LEN && nb != kill_after; c++) begin
      si_valid = 1'b1;
      si_data  = si_bits[nb];
      so_ready = ph;
      ph = ~ph;
      @(negedge clk);
      if (c == 0) check("scan_clk_off", {31'd0, dut_clk_en}, 32'd0);
      if (so_valid === 1'b1) begin
        so_bits[nb] = so_data;
        nb++;
      end
      cyc();
    end
    si_valid = 1'b0;
    so_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [SW-1:0] arg;
    int            hold;
    int            exp_en;
    int            exp_done;
  } vec_t;

  vec_t           tbl[7];
  logic [31:0]    c0;
  int             d0, s0, o0, nb;
  logic [LEN-1:0] sob;
  logic [LEN-1:0] bits;

  initial begin
    tbl[0] = '{2'd1, 16'd0,  9, 10, 0};
    tbl[1] = '{2'd1, 16'd0,  0,  1, 0};
    tbl[2] = '{2'd2, 16'd3,  6,  3, 1};
    tbl[3] = '{2'd2, 16'd0,  3,  0, 1};
    tbl[4] = '{2'd2, 16'd1,  4,  1, 1};
    tbl[5] = '{2'd2, 16'd17, 20, 17, 1};
    tbl[6] = '{2'd0, 16'd0,  2,  0, 0};

    cyc();
    mon_on = 1'b1;
    cyc();
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check("idle_clk_en", {31'd0, dut_clk_en}, 32'd0);
      check("idle_scan_en", {31'd0, scan_en}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("idle_cycle_count", cycle_count, 32'd0);
      cyc();
    end

    for (int i = 0; i < 7; i++) begin
      c0 = cycle_count;
      d0 = done_cnt;
      issue(tbl[i].op, tbl[i].arg);
      repeat (tbl[i].hold) cyc();
      issue(2'd0, '0);
      @(negedge clk);
      check("tbl_stop_clk_en", {31'd0, dut_clk_en}, 32'd0);
      cyc();
      cyc();
      @(negedge clk);
      check("tbl_en_cycles", cycle_count - c0, tbl[i].exp_en);
      check("tbl_done_pulses", done_cnt - d0, tbl[i].exp_done);
      check("tbl_idle", {29'd0, cmd_ready, busy, dut_clk_en}, 32'b100);
      cyc();
    end

    chain_val = 9'h1A5;
    chain_load = 1'b1;
    cyc();
    chain_load = 1'b0;
    s0 = se_cnt; d0 = done_cnt;
    do_scan(9'h0F3, -1, sob, nb);
    repeat (2) cyc();
    @(negedge clk);
    check("scan_beats", nb, LEN);
    check("scan_so_bits", {23'd0, sob}, 32'h1A5);
    check("scan_chain", {23'd0, chain}, 32'h0F3);
    check("scan_en_pulses", se_cnt - s0, LEN);
    check("scan_done_pulses", done_cnt - d0, 1);
    cyc();

    issue(2'd1, '0);
    repeat (3) cyc();
    o0 = overlap_cnt; d0 = done_cnt;
    bits = 9'h15A;
    do_scan(bits, -1, sob, nb);
    repeat (2) cyc();
    @(negedge clk);
    check("runscan_beats", nb, LEN);
    check("runscan_overlap", overlap_cnt - o0, 0);
    check("runscan_done", done_cnt - d0, 1);
    check("runscan_idle", {29'd0, cmd_ready, busy, dut_clk_en}, 32'b100);
    check("runscan_chain", {23'd0, chain}, {23'd0, bits});
    cyc();

    do_scan(9'h0AA, 4, sob, nb);
    check("abort_beats", nb, 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", {27'd0, cmd_ready, busy, done, dut_clk_en, scan_en}, 32'b10000);
    check("abort_cycle_count", cycle_count, 32'd0);
    cyc();
    s0 = se_cnt; d0 = done_cnt;
    bits = 9'h0C3;
    do_scan(bits, -1, sob, nb);
    repeat (2) cyc();
    check("rescan_beats", nb, LEN);
    check("rescan_en_pulses", se_cnt - s0, LEN);
    check("rescan_done", done_cnt - d0, 1);
    check("rescan_chain", {23'd0, chain}, {23'd0, bits});

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      cmd_valid = ($urandom_range(0, 4) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_arg   = SW'($urandom_range(0, 9));
      si_valid  = 1'($urandom);
      si_data   = 1'($urandom);
      so_ready  = 1'($urandom);
      cyc();
    end
    rst = 1'b0; cmd_valid = 1'b0; si_valid = 1'b0; so_ready = 1'b0;
    cyc();
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Sequencer for the emulation scan chain of an instrumented DUT. Gates the DUT functional clock enable (run, stop, step N cycles) and performs a full-length scan swap, streaming captured bits out to the host while streaming replacement bits in. It sits between the host command/bit-stream interface and the scan-inserted flops; it never touches chain contents except by shifting.

## Interface
- CHAIN_LEN, 9: number of flops in the scan chain; must be ≥ 1.
- STEP_W, 16: width of the step-count argument.
- clk  input  1  single clock for controller and DUT chain.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  command: 0 STOP, 1 RUN, 2 STEP, 3 SCAN.
- cmd_arg  input  STEP_W  STEP cycle count; ignored for other ops.
- si_valid  input  1  host scan-in bit valid.
- si_ready  output  1  scan-in bit consumed this cycle.
- si_data  input  1  scan-in bit.
- so_valid  output  1  scan-out bit valid.
- so_ready  input  1  host can take a scan-out bit.
- so_data  output  1  scan-out bit.
- dut_clk_en  output  1  DUT functional clock enable.
- scan_en  output  1  chain shift strobe; chain shifts one position on each clk edge where high.
- scan_in  output  1  bit entering the chain head.
- scan_out  input  1  bit at the chain tail.
- busy  output  1  high in STEP and SHIFT states.
- done  output  1  one-cycle completion pulse for STEP and SCAN.
- cycle_count  output  32  number of cycles with dut_clk_en high since reset.

## Operation
- States: IDLE, RUN, STEP, SHIFT.
- Reset: IDLE; dut_clk_en=0, scan_en=0, busy=0, done=0, cycle_count=0, internal counters 0. Reset mid-STEP or mid-SHIFT aborts immediately. Chain contents are left partially shifted and are not restored.
- cmd_ready = 1 in IDLE and RUN, 0 in STEP and SHIFT. A command is accepted on a clk edge where cmd_valid and cmd_ready are both high.
- STOP: from any accepting state, go to IDLE.
- RUN: go to RUN. RUN while already in RUN is a no-op.
- STEP k: go to STEP with counter=k. dut_clk_en is high for exactly k cycles, then the block returns to IDLE with done pulsed. k=0: return to IDLE next cycle, done pulses, no enabled cycles. STEP accepted in RUN: the DUT stays enabled for exactly k more cycles, with no gap cycle.
- SCAN: go to SHIFT with beat counter=0. dut_clk_en=0 throughout SHIFT.
- A shift beat occurs in a SHIFT cycle where si_valid and so_ready are both high. During a beat: scan_en=1, si_ready=1, so_valid=1, scan_in=si_data, so_data=scan_out.
- Outside a beat, scan_en, si_ready and so_valid are 0. scan_in and so_data are don't-care.
- These beat outputs are combinational from si_valid/so_ready, gated by the registered state.
- First bit out is the tail flop; the first bit in ends up at the tail after CHAIN_LEN beats. A full SCAN therefore replaces the chain with the host's bits, in order.
- When beat CHAIN_LEN is taken, go to IDLE; done pulses in the following cycle. State is always IDLE after a SCAN, even if it was issued from RUN.
- cycle_count increments on each edge with dut_clk_en=1 and wraps modulo 2^32.
- busy = state is STEP or SHIFT.

## Timing
- Command accepted at edge N: the new state and its dut_clk_en value take effect in cycle N+1. Example: RUN accepted at edge N gives dut_clk_en=1 from cycle N+1; STOP accepted at edge N gives dut_clk_en=0 from cycle N+1.
- STEP k accepted at edge N: dut_clk_en=1 in cycles N+1..N+k. In cycle N+k+1: dut_clk_en=0, done=1, cmd_ready=1.
- SCAN accepted at edge N: the first beat can occur in cycle N+1. Minimum SCAN duration is CHAIN_LEN cycles, and host stalls extend it.
- dut_clk_en and scan_en are never high in the same cycle.
- done is registered and lasts exactly one cycle. A new command may be accepted in the same cycle done is high.

## Test plan
- Reset, then idle 5 cycles: dut_clk_en=0, scan_en=0, done=0, cmd_ready=1, cycle_count=0.
- RUN, wait 10 cycles, STOP: cycle_count=10; dut_clk_en drops the cycle after STOP acceptance.
- STEP 3 from IDLE: dut_clk_en high exactly 3 cycles, then done for 1 cycle, cycle_count=3. STEP 0: done next cycle, cycle_count unchanged.
- Chain (CHAIN_LEN=9) preloaded with 9'h1A5; SCAN with si bits 9'h0F3 (LSB first), so_ready toggling every other cycle:
  - so bits are 9'h1A5, tail first.
  - The chain then holds 9'h0F3.
  - scan_en pulses exactly 9 times.
  - done pulses once.
- RUN, then SCAN while running: dut_clk_en=0 from the cycle after acceptance, scan_en is never coincident with dut_clk_en, and the block is in IDLE after done.
- rst asserted after 4 of 9 beats: IDLE on the next cycle with all outputs at reset values. A following SCAN performs a full 9 beats.
